// File: rtl/sev_code_sequencer.sv
// Display-code sequencer feeding the seven-segment decoder: steps 0..MAX_CODE on a prescaled tick or by manual pulses.
// Optional build macro SEQ_DIR_EN adds the i_dir input for down-counting.
module sev_code_sequencer #(
    parameter int unsigned DIV_COUNT = 25000000,
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned MAX_CODE  = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_step,
`ifdef SEQ_DIR_EN
    input  logic       i_dir,
`endif
    output logic [3:0] o_code,
    output logic       o_code_stb,
    output logic       o_wrap,
    output logic       o_running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [3:0]       CODE_MAX = 4'(MAX_CODE);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       code_next;
    logic             stb_next;
    logic             wrap_next;
    logic             tick;
    logic             advance;
    logic             clear;
    logic             count_down;

`ifdef SEQ_DIR_EN
    assign count_down = i_dir;
`else
    assign count_down = 1'b0;
`endif

    assign tick = (state == RUN) && (cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            o_code     <= 4'd0;
            o_code_stb <= 1'b0;
            o_wrap     <= 1'b0;
            o_running  <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            o_code     <= code_next;
            o_code_stb <= stb_next;
            o_wrap     <= wrap_next;
            o_running  <= (next_state == RUN);
        end
    end

    // Pulse priority is stop > start > step in every state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!i_stop && i_start) next_state = RUN;
            end
            RUN: begin
                if (i_stop) next_state = PAUSE;
            end
            PAUSE: begin
                if (i_stop)       next_state = IDLE;
                else if (i_start) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // In RUN the prescaler keeps counting on the stop edge, so a resume picks up the elapsed phase.
    always_comb begin
        cnt_next  = cnt;
        advance   = 1'b0;
        clear     = 1'b0;
        code_next = o_code;
        stb_next  = 1'b0;
        wrap_next = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (i_stop)                   clear   = 1'b1;
                else if (!i_start && i_step)  advance = 1'b1;
            end
            RUN: begin
                cnt_next = tick ? '0 : cnt + CNT_W'(1);
                advance  = tick && !i_stop;
            end
            PAUSE: begin
                if (i_stop) begin
                    clear    = 1'b1;
                    cnt_next = '0;
                end else if (!i_start && i_step) begin
                    advance = 1'b1;
                end
            end
            default: cnt_next = '0;
        endcase

        if (clear) begin
            code_next = 4'd0;
            stb_next  = (o_code != 4'd0);
        end else if (advance) begin
            stb_next = 1'b1;
            if (count_down) begin
                if (o_code == 4'd0) begin
                    code_next = CODE_MAX;
                    wrap_next = 1'b1;
                end else begin
                    code_next = o_code - 4'd1;
                end
            end else begin
                if (o_code >= CODE_MAX) begin
                    code_next = 4'd0;
                    wrap_next = 1'b1;
                end else begin
                    code_next = o_code + 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/sev_code_sequencer.md
Name: sev_code_sequencer

Overview:
- Upstream stage for the seven-segment decoder: generates the 4-bit display code that the decoder turns into segment drive.
- Steps the code 0..MAX_CODE on a prescaled timebase (RUN), or one step per pulse under manual control (IDLE/PAUSE).
- Start/stop/step inputs are single-cycle pulses from the button conditioning logic.
- o_code connects directly to the decoder's code input.

Parameters:
- DIV_COUNT, 25000000, clock cycles per automatic step; legal range >= 2.
- CNT_W, 25, prescaler width; must satisfy 2^CNT_W >= DIV_COUNT.
- MAX_CODE, 6, highest code emitted before wrap; legal range 0..15.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse: start or resume automatic stepping.
- i_stop  in  1  pulse: pause if running, clear if paused or idle.
- i_step  in  1  pulse: manual single advance; ignored while running.
- o_code  out  4  current display code, always <= MAX_CODE.
- o_code_stb  out  1  one-cycle pulse, high in the first cycle o_code shows a new value.
- o_wrap  out  1  one-cycle pulse coincident with o_code_stb when the code wraps.
- o_running  out  1  high while in RUN.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- Reset values, applied immediately on i_rst_n low, including mid-run:
  - state IDLE, prescaler 0
  - o_code 0, o_code_stb 0, o_wrap 0, o_running 0
- All outputs are registered.
- States:
  - IDLE: prescaler held at 0, code held.
  - RUN: prescaler counts 0..DIV_COUNT-1. The edge on which it equals DIV_COUNT-1 is a tick: prescaler returns to 0 and the code advances.
  - PAUSE: prescaler and code both held.
- Transitions, all at the clock edge where the pulse is sampled:
  - IDLE + start -> RUN, prescaler cleared.
  - RUN + stop -> PAUSE.
  - PAUSE + start -> RUN, prescaler resumes from its held value.
  - PAUSE + stop -> IDLE, code cleared to 0.
  - IDLE + stop -> stays IDLE, code cleared to 0.
  - RUN + start -> no effect.
- Priority when pulses coincide: stop > start > step. If stop and tick land on the same edge in RUN, stop wins and the code does not advance.
- Step: in IDLE or PAUSE, i_step advances the code once at that edge. Ignored in RUN.
- Advance arithmetic:
  - code == MAX_CODE -> 0, with o_wrap and o_code_stb both high for one cycle.
  - otherwise code + 1, with o_code_stb high for one cycle.
  - MAX_CODE == 0: every advance is a wrap 0 -> 0, and o_code_stb and o_wrap still pulse.
- Clear strobes: a stop-clear pulses o_code_stb only if o_code was nonzero; it never pulses o_wrap.
- Latency: start sampled at edge k -> first advance at edge k+DIV_COUNT, then one advance every DIV_COUNT cycles.
- After a pause, resume takes DIV_COUNT minus the elapsed count before the next advance.
- o_running rises one cycle after the start edge and falls one cycle after the stop edge, i.e. it is registered with the state.

Optional Feature:
- Macro: SEQ_DIR_EN.
- Defined:
  - Adds port i_dir (in, 1 bit), sampled at each advance.
  - i_dir = 0 counts up (as above).
  - i_dir = 1 counts down: code 0 -> MAX_CODE with o_wrap; otherwise code - 1.
  - Applies to both ticks and steps.
- Undefined: the port is absent and counting is always up.

Test Plan (DIV_COUNT=4, MAX_CODE=6):
- Reset then start pulse at cycle 0 -> o_code steps 1,2,3 at cycles 4,8,12; o_code_stb high exactly on those cycles; o_running=1 from cycle 1.
- Run through 6 -> next tick gives o_code=0 with o_wrap=1 and o_code_stb=1 for one cycle only.
- Start, stop at cycle 6 (prescaler=2), start at cycle 20 -> next advance at cycle 22; code held at 1 throughout the pause.
- In PAUSE with code=3: step -> 4; stop+step same cycle -> code 0, one stb pulse, no wrap, state IDLE.
- Stop and tick on the same edge in RUN -> no advance, state PAUSE. Assert i_rst_n low mid-run -> all outputs 0 without waiting for a clock edge.
- With SEQ_DIR_EN, i_dir=1, code=0, step -> o_code=6 with o_wrap=1.
